// File: rtl/vga_sync.sv
// Pixel-rate VGA timing generator: coordinates, active-video qualifier, line/frame
// markers and hsync/vsync with a programmable alignment delay for the sync pair.
`timescale 1ns/1ps
module vga_sync #(
  parameter int h_active   = 640,
  parameter int h_front    = 16,
  parameter int h_sync     = 96,
  parameter int h_back     = 48,
  parameter int v_active   = 480,
  parameter int v_front    = 10,
  parameter int v_sync     = 2,
  parameter int v_back     = 33,
  parameter bit sync_pol   = 1'b0,
  parameter int sync_delay = 1
) (
  input  logic       clk,
  input  logic       reset,
  output logic [9:0] x_px,
  output logic [9:0] y_px,
  output logic       activevideo,
  output logic       line_start,
  output logic       frame_start,
  output logic       hsync,
  output logic       vsync
);

  localparam int h_total = h_active + h_front + h_sync + h_back;
  localparam int v_total = v_active + v_front + v_sync + v_back;

  generate
    if (h_total > 1024 || v_total > 1024) begin : g_bad_total
      $error("vga_sync: h_total and v_total must not exceed 1024");
    end
    if (sync_delay < 0 || sync_delay > 7) begin : g_bad_delay
      $error("vga_sync: sync_delay must be in 0..7");
    end
  endgenerate

  // 11-bit window bounds so a sync window ending exactly at 1024 cannot alias to 0
  localparam logic [9:0]  h_last     = 10'(h_total - 1);
  localparam logic [9:0]  v_last     = 10'(v_total - 1);
  localparam logic [10:0] h_vis_end  = 11'(h_active);
  localparam logic [10:0] v_vis_end  = 11'(v_active);
  localparam logic [10:0] hs_start   = 11'(h_active + h_front);
  localparam logic [10:0] hs_end     = 11'(h_active + h_front + h_sync);
  localparam logic [10:0] vs_start   = 11'(v_active + v_front);
  localparam logic [10:0] vs_end     = 11'(v_active + v_front + v_sync);

  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic       h_vis;
  logic       v_vis;
  logic       hs_raw;
  logic       vs_raw;
  logic       hs_q;
  logic       vs_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_cnt <= 10'd0;
      v_cnt <= 10'd0;
    end else if (h_cnt == h_last) begin
      h_cnt <= 10'd0;
      v_cnt <= (v_cnt == v_last) ? 10'd0 : v_cnt + 10'd1;
    end else begin
      h_cnt <= h_cnt + 10'd1;
    end
  end

  always_comb begin
    h_vis  = ({1'b0, h_cnt} < h_vis_end);
    v_vis  = ({1'b0, v_cnt} < v_vis_end);
    hs_raw = ({1'b0, h_cnt} >= hs_start && {1'b0, h_cnt} < hs_end) ? sync_pol : ~sync_pol;
    vs_raw = ({1'b0, v_cnt} >= vs_start && {1'b0, v_cnt} < vs_end) ? sync_pol : ~sync_pol;
  end

  // All coordinate-side outputs come from one register stage so they stay skew-free
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_px        <= 10'd0;
      y_px        <= 10'd0;
      activevideo <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      hs_q        <= ~sync_pol;
      vs_q        <= ~sync_pol;
    end else begin
      x_px        <= h_cnt;
      y_px        <= v_cnt;
      activevideo <= h_vis && v_vis;
      line_start  <= (h_cnt == 10'd0);
      frame_start <= (h_cnt == 10'd0) && (v_cnt == 10'd0);
      hs_q        <= hs_raw;
      vs_q        <= vs_raw;
    end
  end

  generate
    if (sync_delay == 0) begin : g_no_delay
      assign hsync = hs_q;
      assign vsync = vs_q;
    end else begin : g_delay
      logic [sync_delay-1:0] hs_pipe;
      logic [sync_delay-1:0] vs_pipe;

      // Every stage clears to the idle level so no stale sync pulse survives a reset
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          hs_pipe <= {sync_delay{~sync_pol}};
          vs_pipe <= {sync_delay{~sync_pol}};
        end else begin
          hs_pipe[0] <= hs_q;
          vs_pipe[0] <= vs_q;
          for (int i = 1; i < sync_delay; i++) begin
            hs_pipe[i] <= hs_pipe[i-1];
            vs_pipe[i] <= vs_pipe[i-1];
          end
        end
      end

      assign hsync = hs_pipe[sync_delay-1];
      assign vsync = vs_pipe[sync_delay-1];
    end
  endgenerate

endmodule

// File: tb/tb_vga_sync.sv
// Directed bench for vga_sync: default geometry at sync_delay 1 and 0, plus a
// small 14x7 geometry at sync_delay 0 and 3 for frame, vsync and mid-frame reset.
`timescale 1ns/1ps
module tb_vga_sync;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;
  always #5 clk = ~clk;

  logic [9:0] def_x, def_y, d0_x, d0_y, sm0_x, sm0_y, sm3_x, sm3_y;
  logic def_av, def_ls, def_fs, def_hs, def_vs;
  logic d0_av, d0_ls, d0_fs, d0_hs, d0_vs;
  logic sm0_av, sm0_ls, sm0_fs, sm0_hs, sm0_vs;
  logic sm3_av, sm3_ls, sm3_fs, sm3_hs, sm3_vs;

  vga_sync u_def (
    .clk(clk), .reset(rst_a), .x_px(def_x), .y_px(def_y), .activevideo(def_av),
    .line_start(def_ls), .frame_start(def_fs), .hsync(def_hs), .vsync(def_vs)
  );

  vga_sync #(.sync_delay(0)) u_d0 (
    .clk(clk), .reset(rst_a), .x_px(d0_x), .y_px(d0_y), .activevideo(d0_av),
    .line_start(d0_ls), .frame_start(d0_fs), .hsync(d0_hs), .vsync(d0_vs)
  );

  vga_sync #(.h_active(8), .h_front(2), .h_sync(2), .h_back(2),
             .v_active(4), .v_front(1), .v_sync(1), .v_back(1), .sync_delay(0)) u_sm0 (
    .clk(clk), .reset(rst_b), .x_px(sm0_x), .y_px(sm0_y), .activevideo(sm0_av),
    .line_start(sm0_ls), .frame_start(sm0_fs), .hsync(sm0_hs), .vsync(sm0_vs)
  );

  vga_sync #(.h_active(8), .h_front(2), .h_sync(2), .h_back(2),
             .v_active(4), .v_front(1), .v_sync(1), .v_back(1), .sync_delay(3)) u_sm3 (
    .clk(clk), .reset(rst_b), .x_px(sm3_x), .y_px(sm3_y), .activevideo(sm3_av),
    .line_start(sm3_ls), .frame_start(sm3_fs), .hsync(sm3_hs), .vsync(sm3_vs)
  );

  int total = 0;
  int bad   = 0;

  task automatic check_val(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Sampled on a negedge right after the first/second rising edge following release
  task automatic check_def_edge(input int edge_no);
    check_val("def_x_edge",  int'(def_x),  edge_no - 1);
    check_val("def_y_edge",  int'(def_y),  0);
    check_val("def_av_edge", int'(def_av), 1);
    check_val("def_ls_edge", int'(def_ls), (edge_no == 1) ? 1 : 0);
    check_val("def_fs_edge", int'(def_fs), (edge_no == 1) ? 1 : 0);
    check_val("def_hs_edge", int'(def_hs), 1);
    check_val("def_vs_edge", int'(def_vs), 1);
    check_val("d0_x_edge",   int'(d0_x),   edge_no - 1);
    check_val("d0_fs_edge",  int'(d0_fs),  (edge_no == 1) ? 1 : 0);
    $display("default release edge %0d: x=%0d y=%0d av=%0d fs=%0d", edge_no, def_x, def_y, def_av, def_fs);
  endtask

  task automatic check_reset_vals(input string tag, input logic [9:0] x, input logic [9:0] y,
                                  input logic av, input logic ls, input logic fs,
                                  input logic hs, input logic vs);
    check_val({tag, "_x"},  int'(x),  0);
    check_val({tag, "_y"},  int'(y),  0);
    check_val({tag, "_av"}, int'(av), 0);
    check_val({tag, "_ls"}, int'(ls), 0);
    check_val({tag, "_fs"}, int'(fs), 0);
    check_val({tag, "_hs"}, int'(hs), 1);
    check_val({tag, "_vs"}, int'(vs), 1);
    $display("reset state %s: x=%0d y=%0d hs=%0d vs=%0d", tag, x, y, hs, vs);
  endtask

  // Releases rst_b at the current negedge and walks ncyc cycles of the 14x7 geometry
  task automatic run_small(input int ncyc, output int hs_low_l0, output int vs_low_f0,
                           output int frames);
    int x, y, e_hs, e_vs, fs_prev;
    int hh[3];
    int vh[3];
    hs_low_l0 = 0;
    vs_low_f0 = 0;
    frames    = 0;
    fs_prev   = -1;
    for (int k = 0; k < 3; k++) begin
      hh[k] = 1;
      vh[k] = 1;
    end
    rst_b = 1'b0;
    for (int n = 0; n < ncyc; n++) begin
      @(negedge clk);
      x    = n % 14;
      y    = (n / 14) % 7;
      e_hs = (x >= 10 && x <= 11) ? 0 : 1;
      e_vs = (y == 5) ? 0 : 1;
      check_val("sm_x",  int'(sm0_x),  x);
      check_val("sm_y",  int'(sm0_y),  y);
      check_val("sm_av", int'(sm0_av), (x < 8 && y < 4) ? 1 : 0);
      check_val("sm_ls", int'(sm0_ls), (x == 0) ? 1 : 0);
      check_val("sm_fs", int'(sm0_fs), (x == 0 && y == 0) ? 1 : 0);
      check_val("sm0_hs", int'(sm0_hs), e_hs);
      check_val("sm0_vs", int'(sm0_vs), e_vs);
      check_val("sm3_x",  int'(sm3_x),  x);
      check_val("sm3_hs", int'(sm3_hs), hh[2]);
      check_val("sm3_vs", int'(sm3_vs), vh[2]);
      hh[2] = hh[1]; hh[1] = hh[0]; hh[0] = e_hs;
      vh[2] = vh[1]; vh[1] = vh[0]; vh[0] = e_vs;
      if (n < 14 && sm0_hs == 1'b0) hs_low_l0++;
      if (n < 98 && sm0_vs == 1'b0) vs_low_f0++;
      if (sm0_fs) begin
        if (fs_prev >= 0) begin
          check_val("sm_frame_period", n - fs_prev, 98);
          frames++;
        end
        fs_prev = n;
      end
    end
  endtask

  initial begin
    int x, y, act_l0, hs_low, hs0_low, ls_prev, hs_l0, vs_f0, nfr;
    act_l0  = 0;
    hs_low  = 0;
    hs0_low = 0;
    ls_prev = -1;
    rst_a = 1'b1;
    rst_b = 1'b1;
    repeat (5) @(negedge clk);
    check_reset_vals("def", def_x, def_y, def_av, def_ls, def_fs, def_hs, def_vs);
    check_reset_vals("sm3", sm3_x, sm3_y, sm3_av, sm3_ls, sm3_fs, sm3_hs, sm3_vs);

    // Default geometry: walk two lines, stopping at x=700,y=1 inside hsync
    rst_a = 1'b0;
    for (int n = 0; n <= 1500; n++) begin
      @(negedge clk);
      x = n % 800;
      y = n / 800;
      if (n < 2) check_def_edge(n + 1);
      check_val("def_x",  int'(def_x),  x);
      check_val("def_y",  int'(def_y),  y);
      check_val("def_av", int'(def_av), (x < 640 && y < 480) ? 1 : 0);
      check_val("def_ls", int'(def_ls), (x == 0) ? 1 : 0);
      check_val("def_fs", int'(def_fs), (x == 0 && y == 0) ? 1 : 0);
      check_val("def_hs", int'(def_hs), (x >= 657 && x <= 752) ? 0 : 1);
      check_val("d0_hs",  int'(d0_hs),  (x >= 656 && x <= 751) ? 0 : 1);
      check_val("def_vs", int'(def_vs), 1);
      check_val("d0_x",   int'(d0_x),   x);
      if (y == 0) begin
        act_l0  += int'(def_av);
        hs_low  += (def_hs == 1'b0) ? 1 : 0;
        hs0_low += (d0_hs == 1'b0) ? 1 : 0;
      end
      if (def_ls) begin
        if (ls_prev >= 0) check_val("line_period", n - ls_prev, 800);
        ls_prev = n;
      end
    end
    check_val("active_per_line", act_l0, 640);
    check_val("hsync_low_d1", hs_low, 96);
    check_val("hsync_low_d0", hs0_low, 96);
    $display("default line: active=%0d hsync_low d1=%0d d0=%0d", act_l0, hs_low, hs0_low);

    // Asynchronous reset while hsync is asserted on both default instances
    check_val("pre_rst_def_hs", int'(def_hs), 0);
    check_val("pre_rst_d0_hs",  int'(d0_hs),  0);
    #2 rst_a = 1'b1;
    #1;
    check_val("async_def_hs", int'(def_hs), 1);
    check_val("async_d0_hs",  int'(d0_hs),  1);
    check_val("async_def_x",  int'(def_x),  0);
    check_val("async_def_y",  int'(def_y),  0);
    $display("default async reset: hs=%0d x=%0d y=%0d", def_hs, def_x, def_y);
    repeat (3) @(negedge clk);
    rst_a = 1'b0;
    @(negedge clk);
    check_def_edge(1);
    @(negedge clk);
    check_def_edge(2);

    // Small geometry: three frames ending at x=11,y=5 where both syncs are asserted
    run_small(278, hs_l0, vs_f0, nfr);
    check_val("sm_hsync_low_line", hs_l0, 2);
    check_val("sm_vsync_low_frame", vs_f0, 14);
    check_val("sm_frames_seen", nfr, 2);
    $display("small geometry: hsync_low=%0d vsync_low=%0d periods=%0d", hs_l0, vs_f0, nfr);
    check_val("pre_rst_sm_hs", int'(sm0_hs), 0);
    check_val("pre_rst_sm_vs", int'(sm0_vs), 0);
    check_val("pre_rst_sm3_vs", int'(sm3_vs), 0);
    #2 rst_b = 1'b1;
    #1;
    check_val("async_sm_hs",  int'(sm0_hs), 1);
    check_val("async_sm_vs",  int'(sm0_vs), 1);
    check_val("async_sm3_vs", int'(sm3_vs), 1);
    check_val("async_sm_x",   int'(sm0_x),  0);
    check_val("async_sm_y",   int'(sm0_y),  0);
    $display("small async reset: hs=%0d vs=%0d x=%0d y=%0d", sm0_hs, sm0_vs, sm0_x, sm0_y);
    repeat (3) @(negedge clk);
    run_small(20, hs_l0, vs_f0, nfr);
    check_val("sm_rerun_hsync_low", hs_l0, 2);
    $display("small rerun after reset: hsync_low=%0d", hs_l0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
